rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter with a bounded hold time.
- Shares one resource whose select lines are one-hot.
- Produces a registered 2-bit owner index, and a one-hot grant built by the team's existing 2-to-4 `decoder`.
- Sits between up to four client blocks and the shared resource's select lines.

Parameters:
- MAX_HOLD, default 8: maximum consecutive grant cycles for one owner while any other requester is waiting. 0 = unlimited (hold until release).
- CNT_W, default 4: hold-counter width. Must satisfy 2**CNT_W >= MAX_HOLD.

Ports:
- clk  input  1: single clock, rising edge.
- rst_n  input  1: asynchronous, active-low reset.
- req  input  4: request vector, bit i = requester i. Level-sensitive; held high for as long as the resource is wanted.
- gnt  output  4: one-hot grant, or 0000 when idle.
- gnt_id  output  2: index of the current owner. Valid only when gnt_valid=1.
- gnt_valid  output  1: high while some requester owns the resource.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous, active-low.
- Values while rst_n=0 (take effect immediately, no clock edge needed):
  - gnt=0000, gnt_id=0, gnt_valid=0
  - state=IDLE, ptr=0, hold_cnt=0
- All state is registered. gnt = decoder(gnt_id) AND {4{gnt_valid}}, so gnt is always one-hot or zero.
- ptr holds the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- State IDLE:
  - If req != 0 at a clock edge, the winner is the first set bit in search order.
  - Next cycle: state=GRANT, gnt_valid=1, gnt_id=winner, hold_cnt=0.
  - Latency from req to gnt is 1 cycle.
- State GRANT, owner o. Evaluated at each edge in priority order:
  - (a) Release: req[o]=0.
    - ptr <= o+1 (3 wraps to 0).
    - If other requests are pending, grant the next winner, searched from the new ptr, in the next cycle. No idle bubble.
    - Otherwise go to IDLE with gnt=0000.
  - (b) Forced rotation: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, req[o]=1, and (req & ~onehot(o)) != 0.
    - ptr <= o+1.
    - Grant the winner searched from o+1, excluding o.
    - hold_cnt <= 0.
    - o therefore holds exactly MAX_HOLD cycles.
  - (c) Otherwise: stay with the same owner; hold_cnt increments, saturating at MAX_HOLD-1.
    - With no competitors, the owner keeps the grant indefinitely.
- Simultaneous events:
  - Release and new requests on the same edge: handled by rule (a).
  - The owner dropping and re-raising req across one cycle counts as a release. The owner then re-competes from ptr=o+1.
- Requests from non-owners never affect the current grant, except via rule (b).
- Reset mid-grant: gnt drops to 0000 asynchronously and ptr returns to 0.
- Arbitration after reset release starts from requester 0.

Decomposition:
- Package `arb_pkg` holds:
  - N_REQ=4 and ID_W=2
  - state enum {IDLE, GRANT}
  - function `rr_pick(req, ptr, excl)` returning the first set index in circular order.
- One sub-module: the existing 2-to-4 one-hot `decoder`, instantiated once to map gnt_id to the raw one-hot vector.
- All other logic is a single always block with asynchronous reset, plus that function.

Test Plan:
1. Reset: rst_n=0 with req=1111 for 3 cycles -> gnt=0000, gnt_valid=0, gnt_id=0 throughout. Then release rst_n with req=1111 -> gnt=0001 one cycle later.
2. Single requester: req=0100 from cycle 0 -> cycle 1 gnt=0100, gnt_id=2. Drop req at cycle 3 -> cycle 4 gnt=0000. Next req=1100 -> grant goes to 3 first (ptr=3).
3. Round robin, MAX_HOLD=0: req=1111, each owner drops its bit for one cycle 2 cycles after being granted and then re-raises it -> owner sequence 0,1,2,3,0 with no idle cycles between grants.
4. Forced rotation, MAX_HOLD=4: req=0011 held constant -> gnt=0001 for 4 cycles, 0010 for 4 cycles, 0001 for 4 cycles. gnt_valid stays 1.
5. Wrap-around: owner 2 releases while req=1001 -> next grant is 3 (ptr=3). Owner 3 releases -> grant is 0.
6. Asynchronous reset mid-grant: owner 1 holding, rst_n pulsed low between clock edges -> gnt=0000 before the next edge. After release, req=1010 -> gnt=0010 (ptr=0, so 1 is found first).

Source files
------------

// File: rtl/rr_arbiter4_pkg.sv
// rtl/rr_arbiter4_pkg.sv - shared sizes, state type and circular pick helper for rr_arbiter4
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic {IDLE, GRANT} state_t;

  // First set bit of (req & ~excl) scanning ptr, ptr+1, ... mod N_REQ; returns ptr if none.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [ID_W-1:0]  ptr,
                                              input logic [N_REQ-1:0] excl);
    logic [N_REQ-1:0] cand;
    logic [ID_W-1:0]  idx;
    cand    = req & ~excl;
    rr_pick = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + ID_W'(i);
      if (cand[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    onehot = N_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// rtl/rr_arbiter4_if.sv - request/grant bundle between clients and rr_arbiter4
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;

  modport master (output req, input gnt, input gnt_id, input gnt_valid);
  modport slave  (input req, output gnt, output gnt_id, output gnt_valid);

endinterface

// File: rtl/rr_arbiter4_decoder.sv
// rtl/rr_arbiter4_decoder.sv - 2-to-4 one-hot decoder
module decoder (
  input  logic [1:0] sel,
  output logic [3:0] dout
);

  assign dout = 4'b0001 << sel;

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-requester round-robin arbiter with bounded hold time
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter4_if.slave  arb
);

  localparam int               HOLD_LAST_I = (MAX_HOLD == 0) ? (2 ** CNT_W - 1) : (MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_LAST_I);
  localparam logic             ROTATE_EN   = (MAX_HOLD != 0);

  state_t           state, state_nx;
  logic [ID_W-1:0]  ptr, ptr_nx;
  logic [ID_W-1:0]  id, id_nx;
  logic [CNT_W-1:0] hold_cnt, hold_nx;
  logic [N_REQ-1:0] others;
  logic [N_REQ-1:0] dec;
  logic             valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      id       <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      id       <= id_nx;
      hold_cnt <= hold_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    id_nx    = id;
    hold_nx  = hold_cnt;
    others   = arb.req & ~onehot(id);
    case (state)
      IDLE: begin
        if (|arb.req) begin
          state_nx = GRANT;
          id_nx    = rr_pick(arb.req, ptr, '0);
          hold_nx  = '0;
        end
      end
      GRANT: begin
        if (!arb.req[id]) begin
          // Release hands straight over to the next waiter without an idle cycle.
          ptr_nx  = id + 2'd1;
          hold_nx = '0;
          if (|others) id_nx = rr_pick(others, id + 2'd1, '0);
          else         state_nx = IDLE;
        end else if (ROTATE_EN && hold_cnt == HOLD_LAST && |others) begin
          ptr_nx  = id + 2'd1;
          id_nx   = rr_pick(arb.req, id + 2'd1, onehot(id));
          hold_nx = '0;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  decoder u_dec (
    .sel  (id),
    .dout (dec)
  );

  assign valid         = (state == GRANT);
  assign arb.gnt_valid = valid;
  assign arb.gnt_id    = id;
  assign arb.gnt       = dec & {N_REQ{valid}};

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - randomized and directed self-checking bench for rr_arbiter4
module tb_rr_arbiter4;

  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: owner index (-1 = idle), priority pointer, cycles held so far.
  int m_owner;
  int m_ptr;
  int m_held;

  always #5 clk = ~clk;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus.slave)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  function automatic int find(input logic [3:0] r, input int start, input int n);
    for (int i = 0; i < n; i++)
      if (r[(start + i) % 4]) return (start + i) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    logic [3:0] rest;
    if (m_owner < 0) begin
      m_owner = find(r, m_ptr, 4);
      m_held  = 1;
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = find(r, m_ptr, 4);
      m_held  = 1;
    end else begin
      rest = r;
      rest[m_owner] = 1'b0;
      if (MAX_HOLD != 0 && m_held >= MAX_HOLD && rest != 4'b0) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = find(r, m_ptr, 3);
        m_held  = 1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    check({tag, "_gnt"}, {3'b0, bus.gnt_valid, bus.gnt}, {3'b0, (m_owner >= 0), eg});
    if (m_owner >= 0) check({tag, "_id"}, {6'b0, bus.gnt_id}, 8'(m_owner));
  endtask

  // Called at a negedge: drive req, let one rising edge happen, check at the next negedge.
  task automatic cyc(input logic [3:0] r, input string tag);
    bus.req = r;
    @(posedge clk);
    if (rst_n) model_edge(r);
    else       model_reset();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] r;
  int         o;

  initial begin
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    model_reset();

    // Reset holds everything idle even with all requests up.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_gnt", {3'b0, bus.gnt_valid, bus.gnt}, 8'h00);
      check("rst_id", {6'b0, bus.gnt_id}, 8'h00);
    end
    rst_n = 1'b1;
    cyc(4'b1111, "t1");
    check("t1_first", {4'b0, bus.gnt}, 8'b0001);

    // Single requester, release to idle, then pointer favours 3.
    do_reset();
    cyc(4'b0100, "t2a");
    check("t2_gnt", {4'b0, bus.gnt}, 8'b0100);
    cyc(4'b0100, "t2b");
    cyc(4'b0100, "t2c");
    cyc(4'b0000, "t2d");
    check("t2_idle", {3'b0, bus.gnt_valid, bus.gnt}, 8'h00);
    cyc(4'b1100, "t2e");
    check("t2_ptr3", {6'b0, bus.gnt_id}, 8'd3);

    // Round robin by release with no idle gaps.
    do_reset();
    cyc(4'b1111, "t3s");
    check("t3_own0", {6'b0, bus.gnt_id}, 8'd0);
    for (int k = 0; k < 4; k++) begin
      o = m_owner;
      cyc(4'b1111, "t3h");
      r = 4'b1111;
      r[o] = 1'b0;
      cyc(r, "t3r");
      check("t3_seq", {3'b0, bus.gnt_valid, 2'b0, bus.gnt_id}, {3'b0, 1'b1, 2'b0, 2'((k + 1) % 4)});
    end

    // Forced rotation after MAX_HOLD cycles.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(4'b0011, "t4");
      check("t4_rot", {3'b0, bus.gnt_valid, bus.gnt},
            {3'b0, 1'b1, ((i >= 4 && i < 8) ? 4'b0010 : 4'b0001)});
    end

    // Wrap-around of the pointer.
    do_reset();
    cyc(4'b0100, "t5a");
    cyc(4'b1001, "t5b");
    check("t5_to3", {6'b0, bus.gnt_id}, 8'd3);
    cyc(4'b0001, "t5c");
    check("t5_to0", {6'b0, bus.gnt_id}, 8'd0);

    // Asynchronous reset between edges.
    do_reset();
    cyc(4'b0010, "t6a");
    #1 rst_n = 1'b0;
    #1;
    check("t6_async", {3'b0, bus.gnt_valid, bus.gnt}, 8'h00);
    model_reset();
    bus.req = 4'b0000;
    #1 rst_n = 1'b1;
    @(negedge clk);
    cyc(4'b1010, "t6b");
    check("t6_after", {4'b0, bus.gnt}, 8'b0010);

    // Random traffic, mostly holding requests steady to exercise hold limits.
    do_reset();
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) r = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 9) == 0 && m_owner >= 0) r[m_owner] = 1'b0;
      cyc(r, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
